// File: rtl/uart_result_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_result_arbiter_pkg
// Description : Shared frame-format constants, FSM state type and width helper
//               for the UART result arbiter and the test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_result_arbiter_pkg;

    localparam int c_def_num_src     = 4;
    localparam int c_def_word_bytes  = 4;
    localparam int c_def_timeout_cyc = 65535;

    localparam logic [3:0] c_hdr_tag = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_HDR_WAIT  = 3'd2,
        ST_BYTE      = 3'd3,
        ST_BYTE_WAIT = 3'd4
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_result_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_result_arbiter_if
// Description : Producer request/data bundle plus the UART byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_result_arbiter_if
    import uart_result_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = c_def_num_src,
    parameter int WORD_BYTES = c_def_word_bytes
);

    localparam int c_src_w = src_w(NUM_SRC);

    logic [NUM_SRC-1:0]              req;
    logic [NUM_SRC*WORD_BYTES*8-1:0] data;
    logic [NUM_SRC-1:0]              ack;
    logic                            start_tx;
    logic [7:0]                      tx_data;
    logic                            txFinish;
    logic                            busy;
    logic [c_src_w-1:0]              cur_src;
    logic                            err;

    modport slave (
        input  req, data, txFinish,
        output ack, start_tx, tx_data, busy, cur_src, err
    );

    modport master (
        output req, data, txFinish,
        input  ack, start_tx, tx_data, busy, cur_src, err
    );

endinterface
`default_nettype wire

// File: rtl/uart_result_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Combinational round-robin picker: first set request at or
//               above the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant
    import uart_result_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = c_def_num_src,
    localparam int SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [SRC_W-1:0]   grant_o,
    output logic               any_req_o
);

    localparam logic [SRC_W:0] c_num = (SRC_W+1)'(NUM_SRC);

    logic [NUM_SRC-1:0] w_rot;
    logic [SRC_W-1:0]   w_off;
    logic [SRC_W:0]     w_sum;

    always_comb begin
        w_rot     = NUM_SRC'({req_i, req_i} >> ptr_i);
        w_off     = '0;
        any_req_o = 1'b0;
        // Scan downward so the lowest rotated offset is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off     = SRC_W'(i);
                any_req_o = 1'b1;
            end
        end
        w_sum = {1'b0, ptr_i} + {1'b0, w_off};
        if (w_sum >= c_num) begin
            w_sum = w_sum - c_num;
        end
        grant_o = w_sum[SRC_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/uart_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_result_arbiter
// Description : Round-robin sharing of one UART byte transmitter; each granted
//               word goes out as a source header followed by its bytes MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_result_arbiter
    import uart_result_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = c_def_num_src,
    parameter int WORD_BYTES  = c_def_word_bytes,
    parameter int TIMEOUT_CYC = c_def_timeout_cyc
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_result_arbiter_if.slave bus
);

    localparam int c_src_w  = src_w(NUM_SRC);
    localparam int c_word_w = WORD_BYTES * 8;
    localparam int c_cnt_w  = src_w(WORD_BYTES);

    localparam logic [c_src_w-1:0] c_last_src  = c_src_w'(NUM_SRC - 1);
    localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(WORD_BYTES - 1);
    localparam bit                 c_tmo_en    = (TIMEOUT_CYC != 0);
    localparam logic [31:0]        c_tmo_last  = 32'(TIMEOUT_CYC - 1);

    state_e                state_q;
    logic [c_src_w-1:0]    ptr_q;
    logic [NUM_SRC-1:0]    ack_q;
    logic                  start_tx_q;
    logic [7:0]            tx_data_q;
    logic                  busy_q;
    logic [c_src_w-1:0]    cur_src_q;
    logic                  err_q;
    logic [c_cnt_w-1:0]    byte_cnt_q;
    logic [31:0]           tmo_q;
    logic [c_word_w-1:0]   buf_q;

    logic [c_word_w-1:0]   w_words [NUM_SRC];
    logic [c_src_w-1:0]    w_grant;
    logic                  w_any_req;
    logic [c_src_w-1:0]    w_ptr_next;
    logic                  w_tmo_hit;
    logic [7:0]            w_msb_byte;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_words[gi] = bus.data[gi*c_word_w +: c_word_w];
    end

    rr_grant #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_grant (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .grant_o   (w_grant),
        .any_req_o (w_any_req)
    );

    assign w_ptr_next = (w_grant == c_last_src) ? '0 : w_grant + c_src_w'(1);
    assign w_tmo_hit  = c_tmo_en && (tmo_q == c_tmo_last);
    assign w_msb_byte = buf_q[c_word_w-1 -: 8];

    // Each start_tx is raised on the transition into HDR/BYTE so that the
    // pulse is visible during the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            ack_q      <= '0;
            start_tx_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            cur_src_q  <= '0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            buf_q      <= '0;
        end else begin
            ack_q      <= '0;
            start_tx_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_any_req) begin
                        buf_q          <= w_words[w_grant];
                        ack_q[w_grant] <= 1'b1;
                        busy_q         <= 1'b1;
                        cur_src_q      <= w_grant;
                        ptr_q          <= w_ptr_next;
                        start_tx_q     <= 1'b1;
                        tx_data_q      <= {c_hdr_tag, 4'(w_grant)};
                        state_q        <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    tmo_q   <= '0;
                    state_q <= ST_HDR_WAIT;
                end
                ST_HDR_WAIT: begin
                    if (bus.txFinish) begin
                        byte_cnt_q <= '0;
                        start_tx_q <= 1'b1;
                        tx_data_q  <= w_msb_byte;
                        buf_q      <= buf_q << 8;
                        state_q    <= ST_BYTE;
                    end else if (w_tmo_hit) begin
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        cur_src_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                ST_BYTE: begin
                    tmo_q   <= '0;
                    state_q <= ST_BYTE_WAIT;
                end
                ST_BYTE_WAIT: begin
                    if (bus.txFinish) begin
                        if (byte_cnt_q == c_last_byte) begin
                            busy_q    <= 1'b0;
                            cur_src_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + c_cnt_w'(1);
                            start_tx_q <= 1'b1;
                            tx_data_q  <= w_msb_byte;
                            buf_q      <= buf_q << 8;
                            state_q    <= ST_BYTE;
                        end
                    end else if (w_tmo_hit) begin
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        cur_src_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.start_tx = start_tx_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.cur_src  = cur_src_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_result_arbiter
// Description : Scoreboard bench for the UART result arbiter with a UART
//               responder model and directed frame scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_result_arbiter;

    localparam int NUM_SRC     = 4;
    localparam int WORD_BYTES  = 4;
    localparam int TIMEOUT_CYC = 20;

    logic clk = 1'b0;
    logic rst;
    logic tx_resp;
    logic tx_spur;

    uart_result_arbiter_if #(.NUM_SRC(NUM_SRC), .WORD_BYTES(WORD_BYTES)) bus ();

    uart_result_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .WORD_BYTES  (WORD_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.txFinish = tx_resp | tx_spur;

    always #5 clk = ~clk;

    int checks  = 0;
    int passes  = 0;
    int cyc     = 0;
    int n_start = 0;
    logic fin_prev = 1'b0;

    logic [7:0]         exp_bytes [$];
    logic [NUM_SRC-1:0] exp_ack   [$];
    logic               exp_err_q [$];
    int                 resp_delay [$];

    logic [31:0] words [NUM_SRC] = '{32'h01020304, 32'h05060708, 32'h11223344, 32'h0A0B0C0D};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        fin_prev <= bus.txFinish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: got %0h with nothing expected or bound expired", name, act);
    endtask

    // Scoreboard monitor: every output event must match the head of its queue.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.start_tx === 1'b1) begin
                n_start++;
                if (exp_bytes.size() == 0) flag_fail("unexpected_tx", bus.tx_data);
                else check("tx_byte", bus.tx_data, exp_bytes.pop_front());
            end
            if (bus.ack !== '0) begin
                if (exp_ack.size() == 0) flag_fail("unexpected_ack", bus.ack);
                else check("ack_grant", bus.ack, exp_ack.pop_front());
            end
            if (bus.err !== 1'b0) begin
                if (exp_err_q.size() == 0) flag_fail("unexpected_err", bus.err);
                else check("err_pulse", bus.err, exp_err_q.pop_front());
            end
        end
    end

    // UART model: answers each start_tx after a delay (negative = withhold).
    int r_d;
    bit r_ab;
    initial begin
        tx_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.start_tx === 1'b1 && rst === 1'b0) begin
                r_d  = (resp_delay.size() > 0) ? resp_delay.pop_front() : 10;
                r_ab = 1'b0;
                if (r_d >= 0) begin
                    for (int k = 0; k < r_d && !r_ab; k++) begin
                        @(posedge clk);
                        if (rst) r_ab = 1'b1;
                    end
                    if (!r_ab) begin
                        #1 tx_resp = 1'b1;
                        @(posedge clk);
                        #1 tx_resp = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int src);
        logic [NUM_SRC-1:0] oh;
        oh      = '0;
        oh[src] = 1'b1;
        exp_ack.push_back(oh);
        exp_bytes.push_back({4'hA, 4'(src)});
        for (int b = WORD_BYTES - 1; b >= 0; b--) exp_bytes.push_back(words[src][b*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) flag_fail(name, bus.busy);
        tick(2);
    endtask

    // Raise r, then drop each source's bit right after its ack.
    task automatic run_reqs(input logic [NUM_SRC-1:0] r, input int n, input string name);
        bus.req = r;
        for (int g = 0; g < n; g++) begin
            int t;
            logic [NUM_SRC-1:0] seen;
            t = 0;
            @(negedge clk);
            while (bus.ack === '0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                flag_fail(name, bus.ack);
                bus.req = '0;
                return;
            end
            seen = bus.ack;
            tick(1);
            bus.req = bus.req & ~seen;
        end
        wait_idle(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int s;
        int t;
        rst     = 1'b1;
        tx_spur = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NUM_SRC; i++) bus.data[i*32 +: 32] = words[i];
        tick(3);
        @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_start_tx", bus.start_tx, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cur_src", bus.cur_src, 0);
        check("rst_err", bus.err, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Single frame from source 2.
        push_frame(2);
        n0 = n_start;
        bus.req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("t1_ack_latency", bus.ack, 4'b0100);
        check("t1_start_with_ack", bus.start_tx, 1);
        check("t1_busy", bus.busy, 1);
        check("t1_cur_src", bus.cur_src, 2);
        tick(1);
        bus.req = '0;
        @(negedge clk);
        check("t1_ack_width", bus.ack, 0);
        t = 0;
        while (bus.busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) flag_fail("t1_busy_wait", bus.busy);
        check("t1_busy_fall_after_fin", fin_prev, 1);
        check("t1_n_start", n_start - n0, 5);
        tick(2);

        // Simultaneous requests and round-robin wrap.
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) push_frame(i);
        run_reqs(4'b1111, 4, "t2_all");
        push_frame(0);
        push_frame(1);
        run_reqs(4'b0011, 2, "t2_pair_a");
        push_frame(0);
        push_frame(1);
        run_reqs(4'b0011, 2, "t2_pair_b");

        // Spurious txFinish in IDLE, HDR and BYTE.
        push_frame(3);
        tx_spur = 1'b1;
        tick(1);
        tx_spur = 1'b0;
        tick(2);
        n0 = n_start;
        bus.req = 4'b1000;
        tick(1);
        tx_spur = 1'b1;
        tick(1);
        tx_spur = 1'b0;
        bus.req = '0;
        tick(10);
        tx_spur = 1'b1;
        tick(1);
        tx_spur = 1'b0;
        wait_idle("t3_idle");
        check("t3_n_start", n_start - n0, 5);

        // Timeout while waiting on the header.
        exp_ack.push_back(4'b0001);
        exp_bytes.push_back(8'hA0);
        exp_err_q.push_back(1'b1);
        resp_delay.push_back(-1);
        bus.req = 4'b0001;
        t = 0;
        @(negedge clk);
        while (bus.start_tx !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) flag_fail("t4_hdr_wait", bus.start_tx);
        s = cyc;
        tick(1);
        bus.req = '0;
        t = 0;
        @(negedge clk);
        while (bus.err !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) flag_fail("t4_err_wait", bus.err);
        check("t4_err_delay", cyc - s, 21);
        check("t4_err_busy", bus.busy, 0);
        tick(2);
        push_frame(1);
        run_reqs(4'b0010, 1, "t4_next");

        // txFinish exactly on the timeout cycle wins.
        push_frame(2);
        resp_delay.push_back(20);
        run_reqs(4'b0100, 1, "t5_collide");

        // Reset in the middle of a frame.
        exp_ack.push_back(4'b0001);
        exp_bytes.push_back(8'hA0);
        exp_bytes.push_back(words[0][31:24]);
        exp_bytes.push_back(words[0][23:16]);
        n0 = n_start;
        bus.req = 4'b0001;
        tick(1);
        bus.req = '0;
        t = 0;
        @(negedge clk);
        while (n_start - n0 < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) flag_fail("t6_byte_wait", n_start - n0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ack", bus.ack, 0);
        check("t6_start_tx", bus.start_tx, 0);
        check("t6_tx_data", bus.tx_data, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_cur_src", bus.cur_src, 0);
        check("t6_err", bus.err, 0);
        check("t6_queue_drained", exp_bytes.size(), 0);
        tick(2);
        push_frame(0);
        push_frame(1);
        run_reqs(4'b0011, 2, "t6_ptr_zero");
        push_frame(3);
        run_reqs(4'b1000, 1, "t6_src3");

        tick(5);
        check("end_bytes_left", exp_bytes.size(), 0);
        check("end_acks_left", exp_ack.size(), 0);
        check("end_errs_left", exp_err_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_result_arbiter.md
Name: uart_result_arbiter

Overview:
- Shares the single UART byte transmitter between up to NUM_SRC result producers (transition counter, k-comparator, error counters, ...).
- Each producer raises a request with a fixed-width result word. The block grants one producer at a time in round-robin order, captures its word, and serializes it MSB-byte-first behind a one-byte source header.
- Uses the same start_tx/txFinish byte handshake the test controller uses today, so the UART transmitter no longer needs to be driven by the main test sequencer.

Parameters:
- NUM_SRC, 4, number of requesters; legal range 2..16 (source ID must fit the header low nibble).
- WORD_BYTES, 4, bytes per result word; legal range 1..8.
- TIMEOUT_CYC, 65535, maximum cycles to wait for txFinish per byte; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_SRC  level request per source; held until that source's ack.
- data  in  NUM_SRC*WORD_BYTES*8  flat result words; source i occupies [i*WORD_BYTES*8 +: WORD_BYTES*8].
- ack  out  NUM_SRC  one-cycle pulse to the granted source when its word is captured.
- start_tx  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  8  byte to transmit; valid with start_tx and held until the next start_tx.
- txFinish  in  1  one-cycle pulse from the UART when the current byte is done.
- busy  out  1  high from grant until the frame ends.
- cur_src  out  SRC_W  index of the granted source; SRC_W = max(1, clog2(NUM_SRC)).
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge):
  - state=IDLE, round-robin pointer=0.
  - ack, start_tx, tx_data, busy, cur_src, err, byte counter and timeout counter all 0.
  - Applies mid-frame as well: the frame is dropped, nothing is retransmitted, and an ack already given stays consumed.
- States: IDLE, HDR, HDR_WAIT, BYTE, BYTE_WAIT.
- IDLE, cycle t, with req != 0:
  - Grant g = first set req bit searching from the pointer upward, wrapping.
  - Capture data word g into the shift buffer.
  - At t+1: ack[g]=1 for one cycle, busy=1, cur_src=g, pointer=(g+1) mod NUM_SRC, state=HDR.
- req is sampled only in IDLE. A request held after its ack is not re-granted until the arbiter returns to IDLE.
- HDR (one cycle): start_tx=1, tx_data={4'hA, g zero-extended to 4 bits}, then go to HDR_WAIT.
- HDR_WAIT:
  - On txFinish: byte counter=0, go to BYTE.
  - The timeout counter starts at 0 on entry and increments every waiting cycle.
- BYTE (one cycle): start_tx=1, tx_data = most significant unsent byte of the buffer, buffer shifted left 8, go to BYTE_WAIT.
- BYTE_WAIT, on txFinish:
  - If byte counter == WORD_BYTES-1: busy=0, cur_src=0, state=IDLE. The next grant can occur in the following cycle, so there is a 2-cycle minimum gap between frames.
  - Otherwise: increment the byte counter and go to BYTE.
- txFinish outside HDR_WAIT/BYTE_WAIT (including the start_tx cycle itself) is ignored and never advances a byte.
- Timeout:
  - Applies when TIMEOUT_CYC != 0 and the waiting counter reaches TIMEOUT_CYC-1 without txFinish.
  - Response: err=1 for one cycle, busy=0, state=IDLE, rest of the frame discarded.
  - If txFinish arrives in that same cycle, txFinish wins and there is no err.
- Latency:
  - req to ack: 1 cycle.
  - req to first start_tx: 1 cycle (same cycle as ack).
  - Frame length = WORD_BYTES+1 bytes.

Decomposition:
- Shared package:
  - State enum.
  - Header tag constant 4'hA.
  - SRC_W width function.
  - Default parameter values, so the top level and the test sequencer agree on the frame format.
- One sub-module: rr_grant. Combinational round-robin priority picker taking req and pointer, returning grant index and any_req. The pointer register stays in the parent.

Test Plan:
- Single frame: NUM_SRC=4, req[2]=1 with word 0x11223344, txFinish returned 10 cycles after each start_tx.
  - ack=4'b0100 for exactly 1 cycle, 1 cycle after req.
  - Bytes sent: A2,11,22,33,44; five start_tx pulses total.
  - busy falls on the cycle after the 5th txFinish.
- Simultaneous requests: req=4'b1111 right after reset, each source dropping req after its ack.
  - Grant order 0,1,2,3.
  - Then req=4'b0011 with pointer=0 gives grant 0 then 1.
  - After serving 1 (pointer=2), req=4'b0011 gives grant 0.
- Spurious txFinish: pulses in IDLE, in the HDR cycle, and in a BYTE cycle.
  - No byte is skipped; exactly WORD_BYTES+1 start_tx pulses per frame.
- Timeout: TIMEOUT_CYC=20, txFinish withheld after the header.
  - err pulse 20 cycles after entering HDR_WAIT, busy=0.
  - A following req[1] frame completes normally with header A1.
- Timeout collision: txFinish asserted on exactly the timeout cycle.
  - No err; frame continues with the first data byte.
- Mid-frame reset: rst=1 for 1 cycle after the 2nd data byte.
  - All outputs 0 on the next cycle, pointer 0.
  - req=4'b1000 then yields header A3 and a full frame.
